// File: rtl/rlecca_feat_pkg.sv
// Shared helpers for the moment feature accumulator: box width, box field offsets
// and the empty-box constant. A box is packed as {minx, maxx, miny, maxy}, with maxy in the LSBs.
package rlecca_feat_pkg;

    localparam int unsigned MAX_BOX_W = 128;

    function automatic int unsigned box_w(input int unsigned xb, input int unsigned yb);
        return 2 * xb + 2 * yb;
    endfunction

    function automatic int unsigned maxy_lsb();
        return 0;
    endfunction

    function automatic int unsigned miny_lsb(input int unsigned yb);
        return yb;
    endfunction

    function automatic int unsigned maxx_lsb(input int unsigned yb);
        return 2 * yb;
    endfunction

    function automatic int unsigned minx_lsb(input int unsigned xb, input int unsigned yb);
        return 2 * yb + xb;
    endfunction

    // Empty box: the min fields are all-ones and the max fields are zero, so the first
    // sample always wins. The caller truncates the result to box_w().
    function automatic logic [MAX_BOX_W-1:0] empty_box(input int unsigned xb,
                                                       input int unsigned yb);
        logic [MAX_BOX_W-1:0] xm;
        logic [MAX_BOX_W-1:0] ym;
        xm = (MAX_BOX_W'(1) << xb) - MAX_BOX_W'(1);
        ym = (MAX_BOX_W'(1) << yb) - MAX_BOX_W'(1);
        return (xm << minx_lsb(xb, yb)) | (ym << miny_lsb(yb));
    endfunction

endpackage

// File: rtl/rlecca_coord_counter.sv
// Raster coordinate counter. It starts LATENCY pixels before the frame origin so that
// (x, y) lines up with the pipelined pixel stream.
module rlecca_coord_counter #(
    parameter int unsigned IMWIDTH  = 512,
    parameter int unsigned IMHEIGHT = 512,
    parameter int unsigned X_BIT    = 9,
    parameter int unsigned Y_BIT    = 9,
    parameter int unsigned LATENCY  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             datavalid,
    input  logic             sof,
    output logic [X_BIT-1:0] x,
    output logic [Y_BIT-1:0] y
);

    localparam logic [X_BIT-1:0] X_INIT = X_BIT'(IMWIDTH - LATENCY);
    localparam logic [X_BIT-1:0] X_LAST = X_BIT'(IMWIDTH - 1);
    localparam logic [Y_BIT-1:0] Y_LAST = Y_BIT'(IMHEIGHT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= X_INIT;
            y <= Y_LAST;
        end else if (sof) begin
            x <= X_INIT;
            y <= Y_LAST;
        end else if (datavalid) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + Y_BIT'(1);
            end else begin
                x <= x + X_BIT'(1);
            end
        end
    end

endmodule

// File: rtl/moment_feature_accumulator.sv
// Accumulates a bounding box, area and coordinate sums for one region and merges in
// partial records. When EMIT is set, the merged record is published on f_*.
module moment_feature_accumulator
    import rlecca_feat_pkg::*;
#(
    parameter int unsigned IMWIDTH  = 512,
    parameter int unsigned IMHEIGHT = 512,
    parameter int unsigned X_BIT    = 9,
    parameter int unsigned Y_BIT    = 9,
    parameter int unsigned AREA_BIT = 19,
    parameter int unsigned SUM_BIT  = 28,
    parameter int unsigned LATENCY  = 3,
    localparam int unsigned BOX_W   = box_w(X_BIT, Y_BIT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                datavalid,
    input  logic                sof,
    input  logic                DAC,
    input  logic                DMG,
    input  logic                CLR,
    input  logic                EMIT,
    input  logic [BOX_W-1:0]    dp_box,
    input  logic [AREA_BIT-1:0] dp_area,
    input  logic [SUM_BIT-1:0]  dp_sumx,
    input  logic [SUM_BIT-1:0]  dp_sumy,
    output logic [BOX_W-1:0]    box,
    output logic [AREA_BIT-1:0] area,
    output logic [SUM_BIT-1:0]  sumx,
    output logic [SUM_BIT-1:0]  sumy,
    output logic                f_valid,
    output logic [BOX_W-1:0]    f_box,
    output logic [AREA_BIT-1:0] f_area,
    output logic [SUM_BIT-1:0]  f_sumx,
    output logic [SUM_BIT-1:0]  f_sumy
);

    localparam int unsigned MINX = minx_lsb(X_BIT, Y_BIT);
    localparam int unsigned MAXX = maxx_lsb(Y_BIT);
    localparam int unsigned MINY = miny_lsb(Y_BIT);
    localparam int unsigned MAXY = maxy_lsb();
    localparam logic [BOX_W-1:0] EMPTY_BOX = BOX_W'(empty_box(X_BIT, Y_BIT));

    logic [X_BIT-1:0] x;
    logic [Y_BIT-1:0] y;

    rlecca_coord_counter #(
        .IMWIDTH  (IMWIDTH),
        .IMHEIGHT (IMHEIGHT),
        .X_BIT    (X_BIT),
        .Y_BIT    (Y_BIT),
        .LATENCY  (LATENCY)
    ) u_coord (
        .clk       (clk),
        .rst       (rst),
        .datavalid (datavalid),
        .sof       (sof),
        .x         (x),
        .y         (y)
    );

    logic [BOX_W-1:0]    box_q, f_box_q;
    logic [AREA_BIT-1:0] area_q, f_area_q;
    logic [SUM_BIT-1:0]  sumx_q, sumy_q, f_sumx_q, f_sumy_q;
    logic                f_valid_q;

    logic [X_BIT-1:0]    w_minx, w_maxx, a_minx, a_maxx, m_minx, m_maxx, d_minx, d_maxx;
    logic [Y_BIT-1:0]    w_miny, w_maxy, a_miny, a_maxy, m_miny, m_maxy, d_miny, d_maxy;
    logic [AREA_BIT-1:0] a_area, m_area;
    logic [SUM_BIT-1:0]  a_sumx, a_sumy, m_sumx, m_sumy;
    logic [BOX_W-1:0]    m_box;

    // One extra bit on each sum exposes the carry that drives saturation.
    logic [AREA_BIT:0]   area_inc, area_add;
    logic [SUM_BIT:0]    sumx_inc, sumy_inc, sumx_add, sumy_add;

    assign w_minx = box_q[MINX +: X_BIT];
    assign w_maxx = box_q[MAXX +: X_BIT];
    assign w_miny = box_q[MINY +: Y_BIT];
    assign w_maxy = box_q[MAXY +: Y_BIT];

    assign d_minx = dp_box[MINX +: X_BIT];
    assign d_maxx = dp_box[MAXX +: X_BIT];
    assign d_miny = dp_box[MINY +: Y_BIT];
    assign d_maxy = dp_box[MAXY +: Y_BIT];

    assign area_inc = {1'b0, area_q} + (AREA_BIT + 1)'(1);
    assign sumx_inc = {1'b0, sumx_q} + (SUM_BIT + 1)'(x);
    assign sumy_inc = {1'b0, sumy_q} + (SUM_BIT + 1)'(y);

    always_comb begin
        a_minx = w_minx;
        a_maxx = w_maxx;
        a_miny = w_miny;
        a_maxy = w_maxy;
        a_area = area_q;
        a_sumx = sumx_q;
        a_sumy = sumy_q;
        if (DAC) begin
            a_minx = (x < w_minx) ? x : w_minx;
            a_maxx = (x > w_maxx) ? x : w_maxx;
            a_miny = (y < w_miny) ? y : w_miny;
            a_maxy = (y > w_maxy) ? y : w_maxy;
            a_area = area_inc[AREA_BIT] ? '1 : area_inc[AREA_BIT-1:0];
            a_sumx = sumx_inc[SUM_BIT] ? '1 : sumx_inc[SUM_BIT-1:0];
            a_sumy = sumy_inc[SUM_BIT] ? '1 : sumy_inc[SUM_BIT-1:0];
        end
    end

    assign area_add = {1'b0, a_area} + {1'b0, dp_area};
    assign sumx_add = {1'b0, a_sumx} + {1'b0, dp_sumx};
    assign sumy_add = {1'b0, a_sumy} + {1'b0, dp_sumy};

    always_comb begin
        m_minx = a_minx;
        m_maxx = a_maxx;
        m_miny = a_miny;
        m_maxy = a_maxy;
        m_area = a_area;
        m_sumx = a_sumx;
        m_sumy = a_sumy;
        if (DMG) begin
            m_minx = (d_minx < a_minx) ? d_minx : a_minx;
            m_maxx = (d_maxx > a_maxx) ? d_maxx : a_maxx;
            m_miny = (d_miny < a_miny) ? d_miny : a_miny;
            m_maxy = (d_maxy > a_maxy) ? d_maxy : a_maxy;
            m_area = area_add[AREA_BIT] ? '1 : area_add[AREA_BIT-1:0];
            m_sumx = sumx_add[SUM_BIT] ? '1 : sumx_add[SUM_BIT-1:0];
            m_sumy = sumy_add[SUM_BIT] ? '1 : sumy_add[SUM_BIT-1:0];
        end
    end

    assign m_box = {m_minx, m_maxx, m_miny, m_maxy};

    // The published record is taken before the clear, so EMIT+CLR hands off a full record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_q     <= EMPTY_BOX;
            area_q    <= '0;
            sumx_q    <= '0;
            sumy_q    <= '0;
            f_box_q   <= EMPTY_BOX;
            f_area_q  <= '0;
            f_sumx_q  <= '0;
            f_sumy_q  <= '0;
            f_valid_q <= 1'b0;
        end else begin
            f_valid_q <= 1'b0;
            if (datavalid) begin
                if (CLR) begin
                    box_q  <= EMPTY_BOX;
                    area_q <= '0;
                    sumx_q <= '0;
                    sumy_q <= '0;
                end else begin
                    box_q  <= m_box;
                    area_q <= m_area;
                    sumx_q <= m_sumx;
                    sumy_q <= m_sumy;
                end
                if (EMIT) begin
                    f_box_q   <= m_box;
                    f_area_q  <= m_area;
                    f_sumx_q  <= m_sumx;
                    f_sumy_q  <= m_sumy;
                    f_valid_q <= 1'b1;
                end
            end
        end
    end

    assign box     = box_q;
    assign area    = area_q;
    assign sumx    = sumx_q;
    assign sumy    = sumy_q;
    assign f_box   = f_box_q;
    assign f_area  = f_area_q;
    assign f_sumx  = f_sumx_q;
    assign f_sumy  = f_sumy_q;
    assign f_valid = f_valid_q;

endmodule

// File: tb/tb_moment_feature_accumulator.sv
// Directed bench for moment_feature_accumulator on an 8x4 frame with LATENCY=1.
module tb_moment_feature_accumulator;

    localparam int unsigned XB = 9;
    localparam int unsigned YB = 9;
    localparam int unsigned AB = 19;
    localparam int unsigned SB = 28;
    localparam int unsigned BW = 2 * XB + 2 * YB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          datavalid = 1'b0, sof = 1'b0;
    logic          DAC = 1'b0, DMG = 1'b0, CLR = 1'b0, EMIT = 1'b0;
    logic [BW-1:0] dp_box = '0;
    logic [AB-1:0] dp_area = '0;
    logic [SB-1:0] dp_sumx = '0, dp_sumy = '0;
    logic [BW-1:0] box, f_box;
    logic [AB-1:0] area, f_area;
    logic [SB-1:0] sumx, sumy, f_sumx, f_sumy;
    logic          f_valid;

    int checks = 0;
    int errors = 0;

    moment_feature_accumulator #(
        .IMWIDTH  (8),
        .IMHEIGHT (4),
        .X_BIT    (XB),
        .Y_BIT    (YB),
        .AREA_BIT (AB),
        .SUM_BIT  (SB),
        .LATENCY  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .datavalid (datavalid),
        .sof       (sof),
        .DAC       (DAC),
        .DMG       (DMG),
        .CLR       (CLR),
        .EMIT      (EMIT),
        .dp_box    (dp_box),
        .dp_area   (dp_area),
        .dp_sumx   (dp_sumx),
        .dp_sumy   (dp_sumy),
        .box       (box),
        .area      (area),
        .sumx      (sumx),
        .sumy      (sumy),
        .f_valid   (f_valid),
        .f_box     (f_box),
        .f_area    (f_area),
        .f_sumx    (f_sumx),
        .f_sumy    (f_sumy)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk_box(input int unsigned mnx, input int unsigned mxx,
                                             input int unsigned mny, input int unsigned mxy);
        return {XB'(mnx), XB'(mxx), YB'(mny), YB'(mxy)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic dv, input logic s, input logic dac, input logic dmg,
                        input logic clr, input logic emit);
        datavalid = dv;
        sof       = s;
        DAC       = dac;
        DMG       = dmg;
        CLR       = clr;
        EMIT      = emit;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_rec(input string tag, input logic [BW-1:0] eb, input int unsigned ea,
                           input int unsigned ex, input int unsigned ey);
        chk({tag, "_box"}, 64'(box), 64'(eb));
        chk({tag, "_area"}, 64'(area), 64'(ea));
        chk({tag, "_sumx"}, 64'(sumx), 64'(ex));
        chk({tag, "_sumy"}, 64'(sumy), 64'(ey));
    endtask

    task automatic chk_xy(input string tag, input int unsigned ex, input int unsigned ey);
        chk({tag, "_x"}, 64'(dut.u_coord.x), 64'(ex));
        chk({tag, "_y"}, 64'(dut.u_coord.y), 64'(ey));
    endtask

    initial begin
        logic [BW-1:0] empty;
        empty = mk_box(511, 0, 511, 0);

        // Reset state
        @(posedge clk);
        #1;
        chk_rec("rst", empty, 0, 0, 0);
        chk("rst_fbox", 64'(f_box), 64'(empty));
        chk("rst_farea", 64'(f_area), 64'(0));
        chk("rst_fvalid", 64'(f_valid), 64'(0));
        chk_xy("rst", 7, 3);
        rst = 1'b0;

        // Counter walk
        idle(1);
        chk_xy("cnt1", 0, 0);
        idle(8);
        chk_xy("cnt9", 0, 1);

        // Accumulate at (2,1), (5,1), (3,2)
        idle(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_rec("acc3", mk_box(2, 5, 1, 2), 3, 10, 4);
        chk_xy("acc3", 4, 2);

        // Walk to (7,3), then EMIT+CLR+DAC there
        idle(11);
        chk_xy("pre_emit", 7, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("emit_fbox", 64'(f_box), 64'(mk_box(2, 7, 1, 3)));
        chk("emit_farea", 64'(f_area), 64'(4));
        chk("emit_fsumx", 64'(f_sumx), 64'(17));
        chk("emit_fsumy", 64'(f_sumy), 64'(7));
        chk("emit_fvalid", 64'(f_valid), 64'(1));
        chk_rec("emit_clr", empty, 0, 0, 0);
        chk_xy("wrap", 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fvalid_drop", 64'(f_valid), 64'(0));

        // Merge from empty to rebuild {2,5,1,2}/3/10/4, then merge the second record
        dp_box  = mk_box(2, 5, 1, 2);
        dp_area = AB'(3);
        dp_sumx = SB'(10);
        dp_sumy = SB'(4);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_rec("mrg1", mk_box(2, 5, 1, 2), 3, 10, 4);
        dp_box  = mk_box(0, 3, 0, 1);
        dp_area = AB'(2);
        dp_sumx = SB'(3);
        dp_sumy = SB'(1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_rec("mrg2", mk_box(0, 5, 0, 2), 5, 13, 5);

        // Controls without datavalid do nothing
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_rec("nodv", mk_box(0, 5, 0, 2), 5, 13, 5);
        chk("nodv_fvalid", 64'(f_valid), 64'(0));

        // Saturation
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_rec("clr", empty, 0, 0, 0);
        dp_box  = empty;
        dp_area = '1;
        dp_sumx = SB'(28'hFFFFFFD);
        dp_sumy = SB'(7);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_rec("sat_load", empty, 20'h7FFFF, 28'hFFFFFFD, 7);
        dp_area = AB'(5);
        dp_sumx = SB'(5);
        dp_sumy = SB'(0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_rec("sat", empty, 20'h7FFFF, 28'hFFFFFFF, 7);

        // sof mid-line reloads the counter
        chk_xy("pre_sof", 5, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_xy("sof", 7, 3);
        idle(1);
        chk_xy("post_sof", 0, 0);

        // Reset during EMIT discards everything
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_emit_fvalid", 64'(f_valid), 64'(0));
        chk("rst_emit_area", 64'(area), 64'(0));
        chk("rst_emit_fbox", 64'(f_box), 64'(empty));
        chk_xy("rst_emit", 7, 3);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_fvalid", 64'(f_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
